// File: rtl/rv32_ctrl_stage.sv
// rv32_ctrl_stage: registered RV32I decode/control stage with handshake, load-use bubbles and flush.
// Optional M-extension decode of RXX funct7=0000001 is enabled by defining CTRL_MEXT_EN.
module rv32_ctrl_stage #(
   parameter int ALU_OP_W = 6,
   parameter int CNT_W    = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [31:0]         instr_i,
   input  logic                flush_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic                alusrc_o,
   output logic [1:0]          a_sel_o,
   output logic [ALU_OP_W-1:0] alu_op_o,
   output logic                mem_to_reg_o,
   output logic                reg_write_o,
   output logic                mem_read_o,
   output logic                mem_write_o,
   output logic                branch_o,
   output logic                jump_o,
   output logic                jalr_o,
   output logic                illegal_o,
   output logic [31:0]         imm_o,
   output logic [4:0]          rs1_o,
   output logic [4:0]          rs2_o,
   output logic [4:0]          rd_o,
   output logic [2:0]          funct3_o,
   output logic [CNT_W-1:0]    stall_cnt_o
);
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_L     = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
`ifdef CTRL_MEXT_EN
   localparam logic MEXT = 1'b1;
`else
   localparam logic MEXT = 1'b0;
`endif

   typedef struct packed {
      logic                alusrc;
      logic [1:0]          a_sel;
      logic [ALU_OP_W-1:0] alu_op;
      logic                mem_to_reg;
      logic                reg_write;
      logic                mem_read;
      logic                mem_write;
      logic                branch;
      logic                jump;
      logic                jalr;
      logic                illegal;
      logic [31:0]         imm;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [2:0]          funct3;
   } ctrl_t;

   logic [6:0]       w_op;
   logic [6:0]       w_f7;
   logic [2:0]       w_f3;
   logic [1:0]       w_cls;
   logic             w_alt;
   logic [2:0]       w_fld;
   logic             w_wr;
   logic             w_m;
   logic             w_hold;
   logic             w_hazard;
   logic             w_uses_rs2;
   logic             w_take;
   ctrl_t            w_d;
   ctrl_t            r_b;
   logic             r_valid;
   logic [CNT_W-1:0] r_cnt;

   assign w_op = instr_i[6:0];
   assign w_f3 = instr_i[14:12];
   assign w_f7 = instr_i[31:25];
   assign w_m  = MEXT && (w_f7 == 7'b0000001);

   always_comb begin
      w_d        = '0;
      w_d.rs1    = instr_i[19:15];
      w_d.rs2    = instr_i[24:20];
      w_d.rd     = instr_i[11:7];
      w_d.funct3 = w_f3;
      w_cls      = 2'b10;
      w_alt      = 1'b0;
      w_fld      = 3'b000;
      w_wr       = 1'b0;
      case (w_op)
         OP_R: begin
            w_cls       = w_m ? 2'b11 : 2'b00;
            w_alt       = w_m ? 1'b0 : w_f7[5];
            w_fld       = w_f3;
            w_wr        = 1'b1;
            w_d.illegal = !((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000) || w_m);
         end
         OP_I: begin
            w_cls      = 2'b00;
            w_alt      = (w_f3 == 3'b101) & w_f7[5];
            w_fld      = w_f3;
            w_wr       = 1'b1;
            w_d.alusrc = 1'b1;
            w_d.imm    = {{20{instr_i[31]}}, instr_i[31:20]};
         end
         OP_B: begin
            w_cls      = 2'b01;
            w_fld      = w_f3;
            w_d.branch = 1'b1;
            w_d.rd     = 5'd0;
            w_d.imm    = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
         end
         OP_LUI: begin
            w_wr       = 1'b1;
            w_d.a_sel  = 2'b10;
            w_d.alusrc = 1'b1;
            w_d.imm    = {instr_i[31:12], 12'b0};
         end
         OP_AUIPC: begin
            w_wr       = 1'b1;
            w_d.a_sel  = 2'b01;
            w_d.alusrc = 1'b1;
            w_d.imm    = {instr_i[31:12], 12'b0};
         end
         OP_JAL: begin
            w_wr       = 1'b1;
            w_d.a_sel  = 2'b01;
            w_d.alusrc = 1'b1;
            w_d.jump   = 1'b1;
            w_d.imm    = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
         end
         OP_JALR: begin
            w_wr       = 1'b1;
            w_d.alusrc = 1'b1;
            w_d.jump   = 1'b1;
            w_d.jalr   = 1'b1;
            w_d.imm    = {{20{instr_i[31]}}, instr_i[31:20]};
         end
         OP_L: begin
            w_wr           = 1'b1;
            w_d.alusrc     = 1'b1;
            w_d.mem_read   = 1'b1;
            w_d.mem_to_reg = 1'b1;
            w_d.imm        = {{20{instr_i[31]}}, instr_i[31:20]};
         end
         OP_S: begin
            w_d.alusrc    = 1'b1;
            w_d.mem_write = 1'b1;
            w_d.rd        = 5'd0;
            w_d.imm       = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         end
         default: begin
            w_cls       = 2'b00;
            w_d.illegal = 1'b1;
         end
      endcase
      w_d.alu_op    = ALU_OP_W'({w_cls, w_alt, w_fld});
      w_d.reg_write = w_wr & ~w_d.illegal & (w_d.rd != 5'd0);
   end

   // rs1 is compared for every opcode; rs2 only where the format actually reads it
   assign w_uses_rs2 = (w_op == OP_R) || (w_op == OP_B) || (w_op == OP_S);
   assign w_hold     = r_valid & ~out_ready_i;
   assign w_hazard   = r_valid & r_b.mem_read & (r_b.rd != 5'd0) & in_valid_i &
                       ((w_d.rs1 == r_b.rd) | ((w_d.rs2 == r_b.rd) & w_uses_rs2));
   assign in_ready_o = ~w_hold & ~w_hazard & ~flush_i;
   assign w_take     = in_valid_i & ~w_hazard;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= 1'b0;
         r_b     <= '0;
         r_cnt   <= '0;
      end else if (flush_i) begin
         r_valid <= 1'b0;
         r_b     <= '0;
      end else if (!w_hold) begin
         r_valid <= w_take;
         r_b     <= w_take ? w_d : '0;
         if (w_hazard && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign out_valid_o  = r_valid;
   assign alusrc_o     = r_b.alusrc;
   assign a_sel_o      = r_b.a_sel;
   assign alu_op_o     = r_b.alu_op;
   assign mem_to_reg_o = r_b.mem_to_reg;
   assign reg_write_o  = r_b.reg_write;
   assign mem_read_o   = r_b.mem_read;
   assign mem_write_o  = r_b.mem_write;
   assign branch_o     = r_b.branch;
   assign jump_o       = r_b.jump;
   assign jalr_o       = r_b.jalr;
   assign illegal_o    = r_b.illegal;
   assign imm_o        = r_b.imm;
   assign rs1_o        = r_b.rs1;
   assign rs2_o        = r_b.rs2;
   assign rd_o         = r_b.rd;
   assign funct3_o     = r_b.funct3;
   assign stall_cnt_o  = r_cnt;
endmodule

// File: tb/tb_rv32_ctrl_stage.sv
// tb_rv32_ctrl_stage: directed scoreboard bench for rv32_ctrl_stage; counter narrowed to 2 bits to reach saturation.
module tb_rv32_ctrl_stage;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic        alusrc;
   logic [1:0]  a_sel;
   logic [5:0]  alu_op;
   logic        mem_to_reg, reg_write, mem_read, mem_write, branch, jump, jalr, illegal;
   logic [31:0] imm;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  funct3;
   logic [1:0]  stall_cnt;
   logic [67:0] sb[$];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   rv32_ctrl_stage #(.ALU_OP_W(6), .CNT_W(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .instr_i(instr), .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .alusrc_o(alusrc), .a_sel_o(a_sel), .alu_op_o(alu_op), .mem_to_reg_o(mem_to_reg),
      .reg_write_o(reg_write), .mem_read_o(mem_read), .mem_write_o(mem_write),
      .branch_o(branch), .jump_o(jump), .jalr_o(jalr), .illegal_o(illegal), .imm_o(imm),
      .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd), .funct3_o(funct3), .stall_cnt_o(stall_cnt)
   );

   // c = {mem_to_reg, reg_write, mem_read, mem_write, branch, jump, jalr, illegal}
   function automatic logic [67:0] mk(input logic v, input logic src, input logic [1:0] as,
                                      input logic [5:0] op, input logic [7:0] c, input logic [31:0] im,
                                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                                      input logic [2:0] f3);
      return {v, src, as, op, c, im, r1, r2, d, f3};
   endfunction

   function automatic logic [67:0] obs();
      return {out_valid, alusrc, a_sel, alu_op, mem_to_reg, reg_write, mem_read, mem_write,
              branch, jump, jalr, illegal, imm, rs1, rs2, rd, funct3};
   endfunction

   task automatic chk(input string tag, input logic [67:0] o, input logic [67:0] x);
      n_vec++;
      assert (o === x) else begin
         n_err++;
         $error("FAIL %s: got %h, want %h", tag, o, x);
      end
   endtask

   task automatic cyc(input string tag, input logic v, input logic [31:0] ins, input logic fl,
                      input logic rdy, input logic x_rdy, input logic [67:0] e, input logic [1:0] x_st);
      @(negedge clk);
      in_valid  = v;
      instr     = ins;
      flush     = fl;
      out_ready = rdy;
      #1;
      chk({tag, ".in_ready"}, 68'(in_ready), 68'(x_rdy));
      sb.push_back(e);
      @(posedge clk);
      #1;
      chk({tag, ".bundle"}, obs(), sb.pop_front());
      chk({tag, ".stall"}, 68'(stall_cnt), 68'(x_st));
   endtask

   localparam logic [31:0] I_ADD3  = 32'h002081B3;
   localparam logic [31:0] I_LW    = 32'h0000A283;
   localparam logic [31:0] I_ADD6  = 32'h00528333;
   localparam logic [31:0] I_SRAI  = 32'h40315093;
   localparam logic [31:0] I_LUI   = 32'h123450B7;
   localparam logic [31:0] I_BEQ   = 32'h00208863;
   localparam logic [31:0] I_SW    = 32'h0020A423;
   localparam logic [31:0] I_JAL   = 32'hFF9FF0EF;
   localparam logic [31:0] I_NOP   = 32'h00000013;
   localparam logic [31:0] I_MUL   = 32'h022081B3;
   localparam logic [31:0] I_BAD   = 32'h0000007F;

   initial begin
      logic [67:0] z, e_add3, e_lw, e_add6, e_srai, e_lui, e_beq, e_sw, e_jal, e_nop, e_mul, e_bad;
      logic [1:0]  st;
      z      = '0;
      e_add3 = mk(1, 0, 2'b00, 6'b000000, 8'b0100_0000, 32'h0, 1, 2, 3, 0);
      e_lw   = mk(1, 1, 2'b00, 6'b100000, 8'b1110_0000, 32'h0, 1, 0, 5, 2);
      e_add6 = mk(1, 0, 2'b00, 6'b000000, 8'b0100_0000, 32'h0, 5, 5, 6, 0);
      e_srai = mk(1, 1, 2'b00, 6'b001101, 8'b0100_0000, 32'h403, 2, 3, 1, 5);
      e_lui  = mk(1, 1, 2'b10, 6'b100000, 8'b0100_0000, 32'h12345000, 8, 3, 1, 5);
      e_beq  = mk(1, 0, 2'b00, 6'b010000, 8'b0000_1000, 32'd16, 1, 2, 0, 0);
      e_sw   = mk(1, 1, 2'b00, 6'b100000, 8'b0001_0000, 32'd8, 1, 2, 0, 2);
      e_jal  = mk(1, 1, 2'b01, 6'b100000, 8'b0100_0100, 32'hFFFFFFF8, 31, 25, 1, 7);
      e_nop  = mk(1, 1, 2'b00, 6'b000000, 8'b0000_0000, 32'h0, 0, 0, 0, 0);
`ifdef CTRL_MEXT_EN
      e_mul  = mk(1, 0, 2'b00, 6'b110000, 8'b0100_0000, 32'h0, 1, 2, 3, 0);
`else
      e_mul  = mk(1, 0, 2'b00, 6'b000000, 8'b0000_0001, 32'h0, 1, 2, 3, 0);
`endif
      e_bad  = mk(1, 0, 2'b00, 6'b000000, 8'b0000_0001, 32'h0, 0, 0, 0, 0);

      rst_n = 1'b0; in_valid = 1'b1; instr = I_ADD3; flush = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.bundle", obs(), z);
      chk("reset.stall", 68'(stall_cnt), 68'd0);
      chk("reset.in_ready", 68'(in_ready), 68'd1);
      @(negedge clk);
      rst_n = 1'b1;

      cyc("add3", 1, I_ADD3, 0, 1, 1, e_add3, 0);
      cyc("lw", 1, I_LW, 0, 1, 1, e_lw, 0);
      cyc("luse_bubble", 1, I_ADD6, 0, 1, 0, z, 1);
      cyc("luse_issue", 1, I_ADD6, 0, 1, 1, e_add6, 1);
      st = 2'd1;
      for (int i = 0; i < 3; i++) begin
         cyc("sat_lw", 1, I_LW, 0, 1, 1, e_lw, st);
         st = (st == 2'd3) ? st : st + 2'd1;
         cyc("sat_bubble", 1, I_ADD6, 0, 1, 0, z, st);
         cyc("sat_issue", 1, I_ADD6, 0, 1, 1, e_add6, st);
      end
      cyc("lw_nodep", 1, I_LW, 0, 1, 1, e_lw, 3);
      cyc("srai_nodep", 1, I_SRAI, 0, 1, 1, e_srai, 3);

      cyc("bp_lw", 1, I_LW, 0, 1, 1, e_lw, 3);
      for (int i = 0; i < 3; i++) cyc("bp_hold", 1, I_ADD6, 0, 0, 0, e_lw, 3);
      cyc("flush", 1, I_ADD6, 1, 0, 0, z, 3);
      cyc("post_flush", 0, I_ADD6, 0, 1, 1, z, 3);

      cyc("lui", 1, I_LUI, 0, 1, 1, e_lui, 3);
      cyc("beq", 1, I_BEQ, 0, 1, 1, e_beq, 3);
      cyc("sw", 1, I_SW, 0, 1, 1, e_sw, 3);
      cyc("jal", 1, I_JAL, 0, 1, 1, e_jal, 3);
      cyc("addi_x0", 1, I_NOP, 0, 1, 1, e_nop, 3);
      cyc("mul", 1, I_MUL, 0, 1, 1, e_mul, 3);
      cyc("bad_op", 1, I_BAD, 0, 1, 1, e_bad, 3);
      cyc("idle", 0, I_BAD, 0, 1, 1, z, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
